// File: rtl/seq_pattern_tx_pkg.sv
// Shared definitions for the serial pattern transmitter and the detector benches.
package seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAPW = 2'd2,
        FIN  = 2'd3
    } tx_state_e;

    localparam int         PAT_W_DEF = 5;
    localparam logic [4:0] PAT_10110 = 5'b10110;

endpackage

// File: rtl/seq_pattern_tx_if.sv
// Control and serial-output bundle of the pattern transmitter.
interface seq_pattern_tx_if #(
    parameter int CNT_W = 4
);
    logic             start;
    logic [CNT_W-1:0] rpt;
    logic             abort;
    logic             sout;
    logic             sval;
    logic             busy;
    logic             done;

    modport master (output start, rpt, abort, input sout, sval, busy, done);
    modport slave  (input start, rpt, abort, output sout, sval, busy, done);
endinterface

// File: rtl/seq_pattern_tx_counter.sv
// Loadable down-counter; decrement saturates at zero.
module ld_down_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic         dec_i,
    input  logic [W-1:0] val_i,
    output logic [W-1:0] cnt_o,
    output logic         zero_o
);
    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i)
            cnt_d = val_i;
        else if (dec_i && cnt_q != '0)
            cnt_d = cnt_q - 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign cnt_o  = cnt_q;
    assign zero_o = (cnt_q == '0);
endmodule

// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter: sends PATTERN MSB-first rpt+1 times with optional idle gaps.
module seq_pattern_tx
    import seq_pkg::*;
#(
    parameter int             PAT_W   = PAT_W_DEF,
    parameter logic [PAT_W-1:0] PATTERN = PAT_10110,
    parameter int             CNT_W   = 4,
    parameter int             GAP     = 0
) (
    input  logic           clk,
    input  logic           rst,
    seq_pattern_tx_if.slave bus
);
    localparam int            BW       = $clog2(PAT_W);
    localparam logic [BW-1:0] BIT_LAST = BW'(PAT_W - 1);
    localparam logic [3:0]    GAP_LAST = (GAP == 0) ? 4'd0 : 4'(GAP - 1);

    tx_state_e        state_q, state_d;
    logic [BW-1:0]    bit_q, bit_nxt;
    logic [3:0]       gap_q;
    logic [CNT_W-1:0] rep_q;
    logic             bit_zero, gap_zero, rep_zero;
    logic             bit_load, bit_dec, gap_load, gap_dec, rep_load, rep_dec;
    logic             sout_q, sval_q, busy_q, done_q;
    logic             sout_d, sval_d, busy_d, done_d;
    logic             unused_ok;

    ld_down_counter #(.W(BW)) u_bit_cnt (
        .clk(clk), .rst(rst), .load_i(bit_load), .dec_i(bit_dec),
        .val_i(BIT_LAST), .cnt_o(bit_q), .zero_o(bit_zero));

    ld_down_counter #(.W(4)) u_gap_cnt (
        .clk(clk), .rst(rst), .load_i(gap_load), .dec_i(gap_dec),
        .val_i(GAP_LAST), .cnt_o(gap_q), .zero_o(gap_zero));

    ld_down_counter #(.W(CNT_W)) u_rep_left (
        .clk(clk), .rst(rst), .load_i(rep_load), .dec_i(rep_dec),
        .val_i(bus.rpt), .cnt_o(rep_q), .zero_o(rep_zero));

    assign unused_ok = ^{gap_q, rep_q};

    always_comb begin
        state_d  = state_q;
        bit_load = 1'b0;
        bit_dec  = 1'b0;
        gap_load = 1'b0;
        gap_dec  = 1'b0;
        rep_load = 1'b0;
        rep_dec  = 1'b0;
        bit_nxt  = bit_q;
        case (state_q)
            IDLE: if (bus.start && !bus.abort) begin
                state_d  = SEND;
                bit_load = 1'b1;
                rep_load = 1'b1;
                bit_nxt  = BIT_LAST;
            end
            SEND: begin
                if (bus.abort) begin
                    state_d = IDLE;
                end else if (!bit_zero) begin
                    bit_dec = 1'b1;
                    bit_nxt = bit_q - 1'b1;
                end else if (rep_zero) begin
                    state_d = FIN;
                end else if (GAP == 0) begin
                    bit_load = 1'b1;
                    rep_dec  = 1'b1;
                    bit_nxt  = BIT_LAST;
                end else begin
                    state_d  = GAPW;
                    gap_load = 1'b1;
                end
            end
            GAPW: begin
                if (bus.abort) begin
                    state_d = IDLE;
                end else if (gap_zero) begin
                    state_d  = SEND;
                    bit_load = 1'b1;
                    rep_dec  = 1'b1;
                    bit_nxt  = BIT_LAST;
                end else begin
                    gap_dec = 1'b1;
                end
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Outputs are registered from the next state so they align with the state they describe.
        sval_d = (state_d == SEND);
        sout_d = sval_d & PATTERN[bit_nxt];
        busy_d = (state_d == SEND) || (state_d == GAPW);
        done_d = (state_d == FIN);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            sout_q  <= 1'b0;
            sval_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sout_q  <= sout_d;
            sval_q  <= sval_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.sout = sout_q;
    assign bus.sval = sval_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;
endmodule

// File: tb/tb_seq_pattern_tx.sv
// Directed bench for seq_pattern_tx; DUT a has GAP=0, DUT b has GAP=2, both share inputs.
module tb_seq_pattern_tx;
    import seq_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;
    logic [4:0]  P   = PAT_10110;
    logic [14:0] S15 = 15'b101101011010110;

    always #5 clk = ~clk;

    seq_pattern_tx_if #(.CNT_W(4)) ia ();
    seq_pattern_tx_if #(.CNT_W(4)) ib ();

    assign ib.start = ia.start;
    assign ib.rpt   = ia.rpt;
    assign ib.abort = ia.abort;

    seq_pattern_tx #(.PAT_W(5), .PATTERN(5'b10110), .CNT_W(4), .GAP(0)) dut_a (
        .clk(clk), .rst(rst), .bus(ia));
    seq_pattern_tx #(.PAT_W(5), .PATTERN(5'b10110), .CNT_W(4), .GAP(2)) dut_b (
        .clk(clk), .rst(rst), .bus(ib));

    function automatic logic [3:0] oa();
        return {ia.sout, ia.sval, ia.busy, ia.done};
    endfunction

    function automatic logic [3:0] ob();
        return {ib.sout, ib.sval, ib.busy, ib.done};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // obs/exp packed as {sout, sval, busy, done}
    task automatic chk(input string tag, input int cyc, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s cycle=%0d observed=%b expected=%b", tag, cyc, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        ia.start = 1'b0;
        ia.abort = 1'b0;
        repeat (n) tick();
    endtask

    initial begin
        ia.start = 1'b0;
        ia.abort = 1'b0;
        ia.rpt   = 4'd0;
        #12;
        chk("reset_a", 0, oa(), 4'b0000);
        chk("reset_b", 0, ob(), 4'b0000);
        rst = 1'b0;
        idle(2);

        // single frame
        ia.rpt = 4'd0; ia.start = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            tick();
            ia.start = 1'b0;
            chk("single_bit", c, oa(), {P[5-c], 3'b110});
        end
        tick(); chk("single_done", 6, oa(), 4'b0001);
        tick(); chk("single_after", 7, oa(), 4'b0000);
        idle(10);

        // back-to-back repeats
        ia.rpt = 4'd2; ia.start = 1'b1;
        for (int c = 1; c <= 15; c++) begin
            tick();
            ia.start = 1'b0;
            chk("b2b_bit", c, oa(), {S15[15-c], 3'b110});
        end
        tick(); chk("b2b_done", 16, oa(), 4'b0001);
        tick(); chk("b2b_after", 17, oa(), 4'b0000);
        idle(25);

        // gap insertion on DUT b
        ia.rpt = 4'd1; ia.start = 1'b1;
        for (int c = 1; c <= 14; c++) begin
            tick();
            ia.start = 1'b0;
            if (c <= 5)       chk("gap_bit", c, ob(), {P[5-c], 3'b110});
            else if (c <= 7)  chk("gap_idle", c, ob(), 4'b0010);
            else if (c <= 12) chk("gap_bit", c, ob(), {P[12-c], 3'b110});
            else if (c == 13) chk("gap_done", c, ob(), 4'b0001);
            else              chk("gap_after", c, ob(), 4'b0000);
        end
        idle(25);

        // abort during the 3rd bit, then immediate restart
        ia.rpt = 4'd0; ia.start = 1'b1;
        for (int c = 1; c <= 3; c++) begin
            tick();
            ia.start = 1'b0;
            chk("abort_pre", c, oa(), {P[5-c], 3'b110});
        end
        ia.abort = 1'b1;
        tick(); ia.abort = 1'b0;
        chk("abort_cut", 4, oa(), 4'b0000);
        ia.start = 1'b1;
        for (int c = 5; c <= 9; c++) begin
            tick();
            ia.start = 1'b0;
            chk("abort_restart", c, oa(), {P[9-c], 3'b110});
        end
        tick(); chk("abort_restart_done", 10, oa(), 4'b0001);
        idle(25);

        // asynchronous reset in the 2nd repeat
        ia.rpt = 4'd2; ia.start = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            tick();
            ia.start = 1'b0;
        end
        chk("rst_pre", 6, oa(), 4'b1110);
        chk("rst_pre_b", 6, ob(), 4'b0010);
        #3 rst = 1'b1;
        #1;
        chk("rst_async_a", 6, oa(), 4'b0000);
        chk("rst_async_b", 6, ob(), 4'b0000);
        tick();
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            tick();
            chk("rst_no_done", c, oa(), 4'b0000);
        end
        ia.rpt = 4'd1; ia.start = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            tick();
            ia.start = 1'b0;
            chk("rst_reframe", c, oa(), {S15[15-c], 3'b110});
        end
        tick(); chk("rst_reframe_done", 11, oa(), 4'b0001);
        idle(25);

        // start during SEND and FIN, rpt change mid-frame
        ia.rpt = 4'd0; ia.start = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            tick();
            ia.start = (c == 2);
            if (c == 3) ia.rpt = 4'd3;
            chk("ign_bit", c, oa(), {P[5-c], 3'b110});
        end
        tick(); chk("ign_done", 6, oa(), 4'b0001);
        ia.start = 1'b1;
        tick(); ia.start = 1'b0;
        chk("ign_fin_start", 7, oa(), 4'b0000);
        tick(); chk("ign_idle", 8, oa(), 4'b0000);
        idle(25);

        // start held high: FIN and IDLE separate frames
        ia.rpt = 4'd0; ia.start = 1'b1;
        for (int c = 1; c <= 15; c++) begin
            tick();
            if (c <= 5)       chk("hold_f1", c, oa(), {P[5-c], 3'b110});
            else if (c == 6)  chk("hold_fin", c, oa(), 4'b0001);
            else if (c == 7)  chk("hold_idle", c, oa(), 4'b0000);
            else if (c <= 12) chk("hold_f2", c, oa(), {P[12-c], 3'b110});
            else if (c == 13) chk("hold_fin2", c, oa(), 4'b0001);
            else if (c == 14) chk("hold_idle2", c, oa(), 4'b0000);
            else              chk("hold_f3", c, oa(), {P[4], 3'b110});
        end
        idle(5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
